// File: rtl/alu_seq.sv
// alu_seq: handshaked, multi-cycle Game Boy ALU; wide ADD/ADC/INC/DEC chain one slice per cycle.
// Define ALU_SEQ_DAA_EN to enable DAA; otherwise DAA passes the accumulator through with no flag write.
module alu_seq #(
    parameter int DATA_W = 8,
    parameter int WORDS  = 2,
    parameter int BI_W   = $clog2(DATA_W)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    ready,
    input  logic [1:0]              op_class,
    input  logic [2:0]              op,
    input  logic                    wide,
    input  logic [BI_W-1:0]         bit_index,
    input  logic [DATA_W*WORDS-1:0] src_data,
    input  logic [DATA_W*WORDS-1:0] dest_data,
    input  logic [7:0]              flags_in,
    output logic [DATA_W*WORDS-1:0] res,
    output logic [7:0]              flags_res,
    output logic                    wr_en_flags,
    output logic                    done
);
    localparam int W  = DATA_W * WORDS;
    localparam int CW = WORDS > 1 ? $clog2(WORDS) : 1;

    typedef enum logic {IDLE, EXEC} state_t;
    state_t state, state_nx;

    logic [1:0]        q_cls;
    logic [2:0]        q_op;
    logic              q_wide;
    logic [BI_W-1:0]   q_bi;
    logic [W-1:0]      q_src, q_dest, work, work_nx;
    logic [3:0]        q_f;
    logic [CW-1:0]     cnt;
    logic              carry_q;
    logic              accept, last, wide_ok, use_sub;
    logic              fz, fn, fh, fc;
    logic [DATA_W-1:0] a, b, x, y, v, r, rot_r;
    logic [DATA_W:0]   add_r, sub_r;
    logic [4:0]        add_n, sub_n;
    logic              cy, cy_out, rot_c, z, n, h, c, wf;
    int unsigned       off;

    assign ready  = state == IDLE;
    assign accept = start && ready;
    assign {fz, fn, fh, fc} = q_f;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE ? (start ? EXEC : IDLE) : (last ? IDLE : EXEC);
    end

    // Only ADD/ADC and INC/DEC may chain; every other wide request runs as a single slice.
    always_comb begin
        wide_ok = q_wide && ((q_cls == 2'b00 && q_op[2:1] == 2'b00) ||
                             (q_cls == 2'b11 && (q_op == 3'd3 || q_op == 3'd4)));
        last    = !wide_ok || cnt == CW'(WORDS - 1);
        off     = int'(cnt) * DATA_W;
        a       = q_dest[off +: DATA_W];
        b       = q_src[off +: DATA_W];
        x       = q_cls == 2'b11 ? b : a;
        y       = q_cls == 2'b11 ? '0 : b;
        use_sub = (q_cls == 2'b00 && (q_op == 3'd2 || q_op == 3'd3 || q_op == 3'd7)) ||
                  (q_cls == 2'b11 && q_op == 3'd4);
        cy      = cnt != '0 ? carry_q :
                  (q_cls == 2'b00 && (q_op == 3'd1 || q_op == 3'd3)) ? fc : q_cls == 2'b11;
        add_r   = {1'b0, x} + {1'b0, y} + (DATA_W+1)'(cy);
        sub_r   = {1'b0, x} - {1'b0, y} - (DATA_W+1)'(cy);
        add_n   = {1'b0, x[3:0]} + {1'b0, y[3:0]} + 5'(cy);
        sub_n   = {1'b0, x[3:0]} - {1'b0, y[3:0]} - 5'(cy);
        cy_out  = use_sub ? sub_r[DATA_W] : add_r[DATA_W];
        v       = q_cls == 2'b01 ? a : b;
        rot_r   = v;
        rot_c   = 1'b0;
        case (q_op)
            3'd0: {rot_c, rot_r} = {v[DATA_W-1], v[DATA_W-2:0], v[DATA_W-1]};
            3'd1: {rot_c, rot_r} = {v[0], v[0], v[DATA_W-1:1]};
            3'd2: {rot_c, rot_r} = {v[DATA_W-1], v[DATA_W-2:0], fc};
            3'd3: {rot_c, rot_r} = {v[0], fc, v[DATA_W-1:1]};
            3'd4: {rot_c, rot_r} = {v[DATA_W-1], v[DATA_W-2:0], 1'b0};
            3'd5: {rot_c, rot_r} = {v[0], v[DATA_W-1], v[DATA_W-1:1]};
            3'd6: {rot_c, rot_r} = {1'b0, v[DATA_W/2-1:0], v[DATA_W-1:DATA_W/2]};
            default: {rot_c, rot_r} = {v[0], 1'b0, v[DATA_W-1:1]};
        endcase
        r  = a;
        z  = fz;
        n  = fn;
        h  = fh;
        c  = fc;
        wf = 1'b1;
        case (q_cls)
            2'b00: case (q_op)
                3'd0, 3'd1: begin
                    r = add_r[DATA_W-1:0];
                    z = wide_ok ? fz : ~|r;
                    {n, h, c} = {1'b0, add_n[4], add_r[DATA_W]};
                end
                3'd2, 3'd3: begin
                    r = sub_r[DATA_W-1:0];
                    z = ~|r;
                    {n, h, c} = {1'b1, sub_n[4], sub_r[DATA_W]};
                end
                3'd4: begin
                    r = a & b;
                    z = ~|r;
                    {n, h, c} = 3'b010;
                end
                3'd5: begin
                    r = a ^ b;
                    z = ~|r;
                    {n, h, c} = 3'b000;
                end
                3'd6: begin
                    r = a | b;
                    z = ~|r;
                    {n, h, c} = 3'b000;
                end
                default: begin
                    z = ~|sub_r[DATA_W-1:0];
                    {n, h, c} = {1'b1, sub_n[4], sub_r[DATA_W]};
                end
            endcase
            2'b01: case (q_op)
                3'd0, 3'd1, 3'd2, 3'd3: begin
                    r = rot_r;
                    {z, n, h, c} = {3'b000, rot_c};
                end
`ifdef ALU_SEQ_DAA_EN
                3'd4: begin
                    r = fn ? a - (fh ? DATA_W'(8'h06) : '0) - (fc ? DATA_W'(8'h60) : '0)
                           : a + ((fh || a[3:0] > 4'd9) ? DATA_W'(8'h06) : '0)
                               + ((fc || a > DATA_W'(8'h99)) ? DATA_W'(8'h60) : '0);
                    c = fn ? fc : (fc || a > DATA_W'(8'h99));
                    z = ~|r;
                    h = 1'b0;
                end
`else
                3'd4: wf = 1'b0;
`endif
                3'd5: begin
                    r = ~a;
                    {n, h} = 2'b11;
                end
                3'd6: {n, h, c} = 3'b001;
                default: {n, h, c} = {2'b00, ~fc};
            endcase
            2'b10: begin
                r = rot_r;
                {z, n, h, c} = {~|rot_r, 2'b00, rot_c};
            end
            default: case (q_op)
                3'd0: begin
                    r = b;
                    {z, n, h} = {~b[q_bi], 2'b01};
                end
                3'd1: begin
                    r  = b & ~(DATA_W'(1) << q_bi);
                    wf = 1'b0;
                end
                3'd2: begin
                    r  = b | (DATA_W'(1) << q_bi);
                    wf = 1'b0;
                end
                3'd3: begin
                    r  = add_r[DATA_W-1:0];
                    wf = !wide_ok;
                    if (!wide_ok)
                        {z, n, h} = {~|r, 1'b0, add_n[4]};
                end
                3'd4: begin
                    r  = sub_r[DATA_W-1:0];
                    wf = !wide_ok;
                    if (!wide_ok)
                        {z, n, h} = {~|r, 1'b1, sub_n[4]};
                end
                default: begin
                    r  = b;
                    wf = 1'b0;
                end
            endcase
        endcase
        work_nx = work | (W'(r) << off);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            carry_q     <= 1'b0;
            work        <= '0;
            res         <= '0;
            flags_res   <= '0;
            done        <= 1'b0;
            wr_en_flags <= 1'b0;
            q_cls       <= '0;
            q_op        <= '0;
            q_wide      <= 1'b0;
            q_bi        <= '0;
            q_src       <= '0;
            q_dest      <= '0;
            q_f         <= '0;
        end else begin
            done        <= 1'b0;
            wr_en_flags <= 1'b0;
            if (accept) begin
                q_cls  <= op_class;
                q_op   <= op;
                q_wide <= wide;
                q_bi   <= bit_index;
                q_src  <= src_data;
                q_dest <= dest_data;
                q_f    <= flags_in[7:4];
                work   <= '0;
                cnt    <= '0;
            end else if (state == EXEC) begin
                carry_q <= cy_out;
                work    <= work_nx;
                cnt     <= last ? '0 : cnt + 1'b1;
                if (last) begin
                    res         <= work_nx;
                    flags_res   <= {z, n, h, c, 4'b0000};
                    wr_en_flags <= wf;
                    done        <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table plus hand-written handshake, reset and DAA sequences for alu_seq.
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        ready;
    logic [1:0]  op_class = '0;
    logic [2:0]  op = '0;
    logic        wide = 1'b0;
    logic [2:0]  bit_index = '0;
    logic [15:0] src_data = '0;
    logic [15:0] dest_data = '0;
    logic [7:0]  flags_in = '0;
    logic [15:0] res;
    logic [7:0]  flags_res;
    logic        wr_en_flags;
    logic        done;

    int total = 0;
    int bad = 0;

    alu_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
        .op_class(op_class), .op(op), .wide(wide), .bit_index(bit_index),
        .src_data(src_data), .dest_data(dest_data), .flags_in(flags_in),
        .res(res), .flags_res(flags_res), .wr_en_flags(wr_en_flags), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  cls;
        logic [2:0]  op;
        logic        wd;
        logic [2:0]  bi;
        logic [15:0] src;
        logic [15:0] dst;
        logic [7:0]  fin;
        logic [15:0] eres;
        logic [7:0]  ef;
        logic        ewe;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[25];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic launch(input logic [1:0] cls, input logic [2:0] o, input logic wd,
                          input logic [2:0] bi, input logic [15:0] s, input logic [15:0] d,
                          input logic [7:0] f);
        op_class = cls; op = o; wide = wd; bit_index = bi;
        src_data = s; dest_data = d; flags_in = f; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        logic seen;
        vecs[0]  = '{2'd0, 3'd2, 1'b0, 3'd0, 16'h0001, 16'h0010, 8'h00, 16'h000F, 8'h60, 1'b1, 1, "sub"};
        vecs[1]  = '{2'd0, 3'd7, 1'b0, 3'd0, 16'h003C, 16'h003C, 8'h00, 16'h003C, 8'hC0, 1'b1, 1, "cp"};
        vecs[2]  = '{2'd0, 3'd1, 1'b0, 3'd0, 16'h0000, 16'h00FF, 8'h10, 16'h0000, 8'hB0, 1'b1, 1, "adc"};
        vecs[3]  = '{2'd0, 3'd0, 1'b1, 3'd0, 16'h0001, 16'h0FFF, 8'h80, 16'h1000, 8'hA0, 1'b1, 2, "wide_add"};
        vecs[4]  = '{2'd3, 3'd4, 1'b1, 3'd0, 16'h0000, 16'h0000, 8'h50, 16'hFFFF, 8'h50, 1'b0, 2, "wide_dec"};
        vecs[5]  = '{2'd0, 3'd4, 1'b0, 3'd0, 16'h000F, 16'h00F0, 8'h00, 16'h0000, 8'hA0, 1'b1, 1, "and"};
        vecs[6]  = '{2'd0, 3'd5, 1'b0, 3'd0, 16'h005A, 16'h005A, 8'h10, 16'h0000, 8'h80, 1'b1, 1, "xor"};
        vecs[7]  = '{2'd0, 3'd6, 1'b0, 3'd0, 16'h0005, 16'h0050, 8'h00, 16'h0055, 8'h00, 1'b1, 1, "or"};
        vecs[8]  = '{2'd0, 3'd3, 1'b0, 3'd0, 16'h0000, 16'h0000, 8'h10, 16'h00FF, 8'h70, 1'b1, 1, "sbc"};
        vecs[9]  = '{2'd0, 3'd0, 1'b0, 3'd0, 16'h00C6, 16'h003A, 8'h00, 16'h0000, 8'hB0, 1'b1, 1, "add"};
        vecs[10] = '{2'd1, 3'd0, 1'b0, 3'd0, 16'h0085, 16'h0085, 8'h80, 16'h000B, 8'h10, 1'b1, 1, "rlca"};
        vecs[11] = '{2'd1, 3'd5, 1'b0, 3'd0, 16'h0035, 16'h0035, 8'h90, 16'h00CA, 8'hF0, 1'b1, 1, "cpl"};
        vecs[12] = '{2'd1, 3'd7, 1'b0, 3'd0, 16'h0012, 16'h0012, 8'hF0, 16'h0012, 8'h80, 1'b1, 1, "ccf"};
        vecs[13] = '{2'd1, 3'd6, 1'b0, 3'd0, 16'h0044, 16'h0044, 8'h00, 16'h0044, 8'h10, 1'b1, 1, "scf"};
        vecs[14] = '{2'd2, 3'd6, 1'b0, 3'd0, 16'h00F1, 16'h00F1, 8'h10, 16'h001F, 8'h00, 1'b1, 1, "swap"};
        vecs[15] = '{2'd2, 3'd7, 1'b0, 3'd0, 16'h0001, 16'h0001, 8'h00, 16'h0000, 8'h90, 1'b1, 1, "srl"};
        vecs[16] = '{2'd2, 3'd3, 1'b0, 3'd0, 16'h0002, 16'h0002, 8'h10, 16'h0081, 8'h00, 1'b1, 1, "rr"};
        vecs[17] = '{2'd3, 3'd0, 1'b0, 3'd7, 16'h007F, 16'h007F, 8'h10, 16'h007F, 8'hB0, 1'b1, 1, "bit"};
        vecs[18] = '{2'd3, 3'd1, 1'b0, 3'd0, 16'h00FF, 16'h00FF, 8'h30, 16'h00FE, 8'h30, 1'b0, 1, "res"};
        vecs[19] = '{2'd3, 3'd2, 1'b0, 3'd3, 16'h0000, 16'h0000, 8'h00, 16'h0008, 8'h00, 1'b0, 1, "set"};
        vecs[20] = '{2'd3, 3'd3, 1'b0, 3'd0, 16'h00FF, 16'h00FF, 8'h10, 16'h0000, 8'hB0, 1'b1, 1, "inc"};
        vecs[21] = '{2'd3, 3'd4, 1'b0, 3'd0, 16'h0010, 16'h0010, 8'h00, 16'h000F, 8'h60, 1'b1, 1, "dec"};
        vecs[22] = '{2'd3, 3'd3, 1'b1, 3'd0, 16'h00FF, 16'h00FF, 8'h20, 16'h0100, 8'h20, 1'b0, 2, "wide_inc"};
        vecs[23] = '{2'd0, 3'd2, 1'b1, 3'd0, 16'h0001, 16'h0110, 8'h00, 16'h000F, 8'h60, 1'b1, 1, "illegal_wide_sub"};
        vecs[24] = '{2'd0, 3'd1, 1'b1, 3'd0, 16'h0000, 16'h00FF, 8'h10, 16'h0100, 8'h00, 1'b1, 2, "wide_adc"};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_res", res, 0);
        chk("reset_flags", flags_res, 0);
        chk("reset_done", done, 0);
        chk("reset_we", wr_en_flags, 0);
        chk("reset_ready", ready, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            chk({vecs[i].name, "_ready"}, ready, 1);
            launch(vecs[i].cls, vecs[i].op, vecs[i].wd, vecs[i].bi, vecs[i].src, vecs[i].dst, vecs[i].fin);
            wait_done(cyc);
            chk({vecs[i].name, "_latency"}, cyc, vecs[i].lat);
            chk({vecs[i].name, "_res"}, res, vecs[i].eres);
            chk({vecs[i].name, "_flags"}, flags_res, vecs[i].ef);
            chk({vecs[i].name, "_we"}, wr_en_flags, vecs[i].ewe);
        end

        // start held through a wide op with new operands: ignored in EXEC, accepted in the done cycle
        op_class = 2'd0; op = 3'd0; wide = 1'b1; src_data = 16'h0001; dest_data = 16'h0FFF;
        flags_in = 8'h80; start = 1'b1;
        @(posedge clk); #1;
        chk("b2b_busy", ready, 0);
        wide = 1'b0; src_data = 16'h0002; dest_data = 16'h0001; flags_in = 8'h00;
        @(posedge clk); #1;
        chk("b2b_no_early_done", done, 0);
        @(posedge clk); #1;
        chk("b2b_done_a", done, 1);
        chk("b2b_res_a", res, 16'h1000);
        chk("b2b_flags_a", flags_res, 8'hA0);
        chk("b2b_ready_in_done", ready, 1);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_accepted", ready, 0);
        chk("b2b_hold_res", res, 16'h1000);
        chk("b2b_done_low", done, 0);
        @(posedge clk); #1;
        chk("b2b_done_b", done, 1);
        chk("b2b_res_b", res, 16'h0003);
        chk("b2b_flags_b", flags_res, 8'h00);

        // reset asserted while the wide op works on slice 1
        launch(2'd0, 3'd0, 1'b1, 3'd0, 16'h0001, 16'h0FFF, 8'h80);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_done", done, 0);
        chk("abort_res", res, 0);
        chk("abort_ready", ready, 1);
        chk("abort_we", wr_en_flags, 0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            seen = seen | done;
        end
        chk("abort_no_late_done", seen, 0);

        launch(2'd0, 3'd0, 1'b0, 3'd0, 16'h0027, 16'h0015, 8'h00);
        wait_done(cyc);
        chk("daa_add_res", res, 16'h003C);
        chk("daa_add_flags", flags_res, 8'h00);
        launch(2'd1, 3'd4, 1'b0, 3'd0, res, res, flags_res);
        wait_done(cyc);
        chk("daa_latency", cyc, 1);
`ifdef ALU_SEQ_DAA_EN
        chk("daa_res", res, 16'h0042);
        chk("daa_flags", flags_res, 8'h00);
        chk("daa_we", wr_en_flags, 1);
`else
        chk("daa_res", res, 16'h003C);
        chk("daa_flags", flags_res, 8'h00);
        chk("daa_we", wr_en_flags, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
